// File: rtl/ram16b_arbiter.sv
// ram16b_arbiter
// Shares one single-port-per-direction ram16b (one write port, one registered
// read port) between two requesters A and B. After reset the RAM is swept to
// zero (optional), then single-word accesses are granted round-robin with a
// combinational same-cycle grant and a one-cycle read-data-valid strobe.

module ram16b_arbiter #(
    parameter int unsigned AW             = 5,
    parameter int unsigned DW             = 16,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic          clk_i,
    input  logic          reset_i,
    output logic          ready_o,

    // Requester A
    input  logic          a_req_i,
    input  logic          a_we_i,
    input  logic [AW-1:0] a_addr_i,
    input  logic [DW-1:0] a_wdat_i,
    output logic          a_gnt_o,
    output logic          a_rvalid_o,
    output logic [DW-1:0] a_rdat_o,

    // Requester B
    input  logic          b_req_i,
    input  logic          b_we_i,
    input  logic [AW-1:0] b_addr_i,
    input  logic [DW-1:0] b_wdat_i,
    output logic          b_gnt_o,
    output logic          b_rvalid_o,
    output logic [DW-1:0] b_rdat_o,

    // RAM side
    output logic [DW-1:0] ram_wdata_o,
    output logic          ram_wen_o,
    output logic [AW-1:0] ram_waddr_o,
    output logic [AW-1:0] ram_raddr_o,
    input  logic [DW-1:0] ram_rdata_i
);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

    typedef enum logic {
        PRIO_A = 1'b0,
        PRIO_B = 1'b1
    } prio_e;

    // Last address of the clear sweep; the sweep covers 0 .. CLR_LAST inclusive.
    localparam logic [AW-1:0] CLR_LAST    = {AW{1'b1}};
    localparam state_e        RESET_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;

    state_e        state_q,   state_d;
    logic [AW-1:0] clr_cnt_q, clr_cnt_d;
    prio_e         prio_q,    prio_d;
    logic          a_rv_q,    a_rv_d;
    logic          b_rv_q,    b_rv_d;

    logic          run;
    logic          a_gnt;
    logic          b_gnt;

    // Arbitration: a lone requester always wins; on contention prio decides.
    // Gating with run keeps requests (even unknown ones) inert during CLEAR.
    assign run   = (state_q == ST_RUN);
    assign a_gnt = run && a_req_i && (!b_req_i || (prio_q == PRIO_A));
    assign b_gnt = run && b_req_i && (!a_req_i || (prio_q == PRIO_B));

    assign ready_o    = run;
    assign a_gnt_o    = a_gnt;
    assign b_gnt_o    = b_gnt;
    assign a_rvalid_o = a_rv_q;
    assign b_rvalid_o = b_rv_q;

    // Both requesters see the RAM read bus; only the own rvalid qualifies it.
    assign a_rdat_o   = ram_rdata_i;
    assign b_rdat_o   = ram_rdata_i;

    // RAM port steering: clear sweep, or the granted requester's access.
    always_comb begin
        // NOTE: every output of a combinational block gets a default before any
        // branch, so no path leaves it unassigned and no latch is inferred.
        ram_wen_o   = 1'b0;
        ram_waddr_o = a_addr_i;
        ram_wdata_o = a_wdat_i;
        ram_raddr_o = a_addr_i;

        if (!run) begin
            ram_wen_o   = 1'b1;
            ram_waddr_o = clr_cnt_q;
            ram_wdata_o = '0;
        end else if (a_gnt) begin
            ram_wen_o   = a_we_i;
            ram_waddr_o = a_addr_i;
            ram_wdata_o = a_wdat_i;
            ram_raddr_o = a_addr_i;
        end else if (b_gnt) begin
            ram_wen_o   = b_we_i;
            ram_waddr_o = b_addr_i;
            ram_wdata_o = b_wdat_i;
            ram_raddr_o = b_addr_i;
        end
    end

    // Next-state logic for the sweep counter, phase, priority and read strobes.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        prio_d    = prio_q;

        unique case (state_q)
            ST_CLEAR: begin
                // Counter stops on the last word; it only returns to 0 via reset.
                if (clr_cnt_q == CLR_LAST) begin
                    state_d = ST_RUN;
                end else begin
                    clr_cnt_d = clr_cnt_q + 1'b1;
                end
            end
            ST_RUN: begin
                // The requester just served yields to the other one.
                if (a_gnt) begin
                    prio_d = PRIO_B;
                end else if (b_gnt) begin
                    prio_d = PRIO_A;
                end
            end
            default: begin
                state_d = RESET_STATE;
            end
        endcase

        // Registered RAM read: data for a read granted now arrives next cycle.
        a_rv_d = a_gnt && !a_we_i;
        b_rv_d = b_gnt && !b_we_i;
    end

    // State registers with synchronous reset; reset drops any in-flight read.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values, independent of statement order.
        if (reset_i) begin
            state_q   <= RESET_STATE;
            clr_cnt_q <= '0;
            prio_q    <= PRIO_A;
            a_rv_q    <= 1'b0;
            b_rv_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            prio_q    <= prio_d;
            a_rv_q    <= a_rv_d;
            b_rv_q    <= b_rv_d;
        end
    end

endmodule
